reg_logic_pipe: RTL and testbench
=================================

# reg_logic_pipe

Parametrised, elastic successor to the single-bit registered AND cells in the pd0 bring-up top. It computes a selectable bitwise logic function of two WIDTH-bit operands and carries the result through a STAGES-deep valid/ready pipeline with full backpressure and an asynchronous reset. It also counts completed output transfers. It is instantiated in the pd top as a probe-able datapath exerciser, and later becomes the logic-unit slice of the execute stage.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits (≥1)
- STAGES, 2, number of pipeline register stages (≥1)

Ports:
- clock  in  1  rising-edge clock
- areset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat offered
- in_ready  out  1  pipeline can accept a beat this cycle
- in_x  in  WIDTH  operand x
- in_y  in  WIDTH  operand y
- in_op  in  2  operation select; sampled with the beat
- out_valid  out  1  result beat available
- out_ready  in  1  consumer accepts the result this cycle
- out_z  out  WIDTH  result
- out_zero  out  1  out_z == 0; qualified by out_valid
- xfer_count  out  16  number of completed output transfers

## Operation
- Encoding of in_op:
  - 00 AND: x & y
  - 01 OR: x | y
  - 10 XOR: x ^ y
  - 11 ANDN: x & ~y
- The function is evaluated combinationally at the input and written into stage 1 on acceptance.
- The zero flag is computed in stage 1 and carried alongside the data.
- Input acceptance: a beat is accepted when in_valid && in_ready at a rising edge.
- Output transfer: a beat transfers when out_valid && out_ready at a rising edge.
- Each stage k (1..STAGES) holds valid_k, data_k and zero_k.
  - ready_k = !valid_k || ready_(k+1), with ready_(STAGES+1) = out_ready.
  - in_ready = ready_1.
- Stage k loads from stage k−1 (stage 0 is the input) when ready_k is high.
  - valid_k takes valid_(k−1) on that load; stage 0 valid is in_valid.
  - When ready_k is low, the stage holds its contents.
- Outputs: out_valid = valid_STAGES, out_z = data_STAGES, out_zero = zero_STAGES.
- Beats are never dropped, duplicated or reordered.
- While out_valid is high and out_ready is low, out_z and out_zero hold stable.
- xfer_count increments by 1 per output transfer and wraps from 0xFFFF to 0x0000.

## Timing
- Reset: while areset is high, all valid_k, data_k, zero_k and xfer_count are 0.
  - Resulting outputs: out_valid=0, out_z=0, out_zero=0, xfer_count=0, in_ready=1.
- Asserting areset mid-operation discards all in-flight beats immediately, with no clock edge needed.
- After areset deasserts, the first accept can occur at the next rising edge.
- Latency: a beat accepted at edge n has out_valid high after edge n+STAGES−1 (visible the cycle before edge n+STAGES), provided no stall occurs.
- Throughput: 1 beat/cycle sustained while out_ready stays high.
- Backpressure:
  - With out_ready low, the pipeline fills; in_ready falls once all STAGES are valid.
  - Capacity is exactly STAGES beats.
- When full and out_ready rises, accept and transfer happen at the same edge.
- in_ready depends combinationally on out_ready through the ready chain. This path is documented, not registered.
- Simultaneous transfer and accept on an empty-to-one pipeline (STAGES=1) is legal and loses no beat.
- in_op, in_x and in_y are don't-care when in_valid is low.

## Structure
- Shared package pd_pkg holds:
  - operation-code localparams (OP_AND, OP_OR, OP_XOR, OP_ANDN)
  - the 2-bit op width constant
- Sub-module reg_logic_stage(WIDTH):
  - one elastic slice containing valid, data and zero registers, async-reset
  - ports: up valid/ready/data, down valid/ready/data
  - the top instantiates STAGES copies in a generate loop, plus the input function and xfer_count

## Test plan
- Reset mid-flow:
  - Stimulus: fill the pipeline, then pulse areset high for 3 ns between edges.
  - Required: out_valid=0, out_z=0 and xfer_count=0 immediately; in_ready=1.
  - Required: no stale beat emerges afterward.
- Op coverage, WIDTH=8, STAGES=2, out_ready=1:
  - Stimulus: x=0xF0, y=0x3C with op 00, 01, 10, 11 on consecutive cycles.
  - Required: out_z = 0x30, 0xFC, 0xCC, 0xC0 appear 2 cycles after their accepts, back-to-back.
- Zero flag:
  - Stimulus: x=0xAA, y=0x55, op=AND.
  - Required: out_z=0x00 with out_zero=1.
  - Then op=OR, which gives out_z=0xFF with out_zero=0.
- Backpressure, STAGES=3:
  - Stimulus: hold out_ready=0 and offer 5 beats.
  - Required: exactly 3 are accepted, then in_ready=0; out_z holds stable.
  - Then release out_ready=1: all 5 beats emerge in order, one per cycle after the pipe drains.
- Random stall:
  - Stimulus: 1000 beats with random in_valid and out_ready.
  - Required: a scoreboard shows in-order, lossless results.
  - Required: xfer_count equals the number of transfers, mod 65536.
- Wrap:
  - Stimulus: 65537 transfers.
  - Required: xfer_count reads 0x0001.

Source files
------------

// File: rtl/pd_pkg.sv
// Shared definitions for the pd datapath blocks: logic-unit operation codes.
package pd_pkg;

   localparam int OP_W = 2;

   localparam logic [OP_W-1:0] OP_AND  = 2'b00;
   localparam logic [OP_W-1:0] OP_OR   = 2'b01;
   localparam logic [OP_W-1:0] OP_XOR  = 2'b10;
   localparam logic [OP_W-1:0] OP_ANDN = 2'b11;

endpackage

// File: rtl/reg_logic_stage.sv
// One elastic pipeline slice: valid, data and zero registers with a
// pass-through ready (a stage accepts when empty or when it is draining).
module reg_logic_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             areset,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [WIDTH-1:0] up_data,
   input  logic             up_zero,
   output logic             down_valid,
   input  logic             down_ready,
   output logic [WIDTH-1:0] down_data,
   output logic             down_zero
);

   logic             valid_p1;
   logic [WIDTH-1:0] data_p1;
   logic             zero_p1;

   assign up_ready = !valid_p1 || down_ready;

   // Stage register: loads whatever is upstream whenever it can accept.
   always_ff @(posedge clock or posedge areset) begin
      if (areset) begin
         valid_p1 <= 1'b0;
         data_p1  <= '0;
         zero_p1  <= 1'b0;
      end else if (up_ready) begin
         valid_p1 <= up_valid;
         data_p1  <= up_data;
         zero_p1  <= up_zero;
      end
   end

   assign down_valid = valid_p1;
   assign down_data  = data_p1;
   assign down_zero  = zero_p1;

endmodule

// File: rtl/reg_logic_pipe.sv
// Selectable bitwise logic unit feeding a STAGES-deep valid/ready pipeline,
// with a wrapping count of completed output transfers.
module reg_logic_pipe
   import pd_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clock,
   input  logic             areset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_y,
   input  logic [OP_W-1:0]  in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_z,
   output logic             out_zero,
   output logic [15:0]      xfer_count
);

   function automatic logic [WIDTH-1:0] logic_fn(input logic [OP_W-1:0] op,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
      case (op)
         OP_AND:  return x & y;
         OP_OR:   return x | y;
         OP_XOR:  return x ^ y;
         default: return x & ~y;
      endcase
   endfunction

   logic [WIDTH-1:0] fn_z_p0;
   logic             fn_zero_p0;

   assign fn_z_p0    = logic_fn(in_op, in_x, in_y);
   assign fn_zero_p0 = (fn_z_p0 == '0);

   // Each slice keeps its own handshake nets so the ready chain stays a
   // plain combinational path from out_ready back to in_ready.
   for (genvar k = 1; k <= STAGES; k++) begin : g_stage
      logic             valid;
      logic             ready;
      logic [WIDTH-1:0] data;
      logic             zero;
      logic             prev_valid;
      logic [WIDTH-1:0] prev_data;
      logic             prev_zero;
      logic             next_ready;

      if (k == 1) begin : g_head
         assign prev_valid = in_valid;
         assign prev_data  = fn_z_p0;
         assign prev_zero  = fn_zero_p0;
      end else begin : g_body
         assign prev_valid = g_stage[k-1].valid;
         assign prev_data  = g_stage[k-1].data;
         assign prev_zero  = g_stage[k-1].zero;
      end

      if (k == STAGES) begin : g_tail
         assign next_ready = out_ready;
      end else begin : g_mid
         assign next_ready = g_stage[k+1].ready;
      end

      reg_logic_stage #(
         .WIDTH(WIDTH)
      ) u_stage (
         .clock      (clock),
         .areset     (areset),
         .up_valid   (prev_valid),
         .up_ready   (ready),
         .up_data    (prev_data),
         .up_zero    (prev_zero),
         .down_valid (valid),
         .down_ready (next_ready),
         .down_data  (data),
         .down_zero  (zero)
      );
   end

   assign in_ready  = g_stage[1].ready;
   assign out_valid = g_stage[STAGES].valid;
   assign out_z     = g_stage[STAGES].data;
   assign out_zero  = g_stage[STAGES].zero;

   // Output transfer counter, wraps naturally at 16 bits.
   always_ff @(posedge clock or posedge areset) begin
      if (areset) begin
         xfer_count <= '0;
      end else if (out_valid && out_ready) begin
         xfer_count <= xfer_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_reg_logic_pipe.sv
// Randomised scoreboard bench for reg_logic_pipe (WIDTH=8, STAGES=3).
module tb_reg_logic_pipe;

   localparam int WIDTH  = 8;
   localparam int STAGES = 3;

   logic             clock = 1'b0;
   logic             areset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_x;
   logic [WIDTH-1:0] in_y;
   logic [1:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_z;
   logic             out_zero;
   logic [15:0]      xfer_count;

   always #5 clock = ~clock;

   reg_logic_pipe #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES)
   ) dut (
      .clock      (clock),
      .areset     (areset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_op      (in_op),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_z      (out_z),
      .out_zero   (out_zero),
      .xfer_count (xfer_count)
   );

   typedef struct {
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic [1:0]       op;
   } beat_t;

   typedef struct {
      logic [WIDTH-1:0] z;
      logic             zero;
      int               cyc;
   } exp_t;

   beat_t stim[$];
   exp_t  sb[$];
   int    rd_ptr;
   int    checks;
   int    errors;
   int    cyc;
   int    n_xfer;
   int    n_acc;
   bit    acc_last;
   bit    rand_valid;
   bit    rand_ready;
   bit    force_ready;
   bit    chk_lat;
   bit    prev_stall;
   logic [WIDTH-1:0] prev_z;
   logic             prev_zero;

   // Reference: per-bit truth table indexed by {x_bit, y_bit}.
   function automatic logic [WIDTH-1:0] ref_fn(input logic [1:0] op,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
      logic [3:0]       tt [4];
      logic [WIDTH-1:0] z;
      tt[0] = 4'b1000;
      tt[1] = 4'b1110;
      tt[2] = 4'b0110;
      tt[3] = 4'b0100;
      for (int i = 0; i < WIDTH; i++) z[i] = tt[op][{x[i], y[i]}];
      return z;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_rand(input int n);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.x  = WIDTH'($urandom);
         b.y  = WIDTH'($urandom);
         b.op = 2'($urandom_range(0, 3));
         stim.push_back(b);
      end
   endtask

   task automatic wait_idle(input int budget, input string what);
      int n = 0;
      while ((rd_ptr < stim.size() || in_valid || sb.size() != 0) && n < budget) begin
         @(negedge clock);
         n++;
      end
      check({"drain_", what}, 32'(n < budget), 32'd1);
   endtask

   task automatic wait_full(input int budget, input string what);
      int n = 0;
      @(negedge clock);
      while (in_ready && n < budget) begin
         @(negedge clock);
         n++;
      end
      check({"fill_", what}, 32'(n < budget), 32'd1);
   endtask

   initial begin
      areset      = 1'b1;
      in_valid    = 1'b0;
      in_x        = '0;
      in_y        = '0;
      in_op       = '0;
      out_ready   = 1'b1;
      force_ready = 1'b1;
      rand_valid  = 1'b0;
      rand_ready  = 1'b0;
      chk_lat     = 1'b0;
      prev_stall  = 1'b0;
      prev_z      = '0;
      prev_zero   = 1'b0;
      acc_last    = 1'b0;
      rd_ptr      = 0;
      checks      = 0;
      errors      = 0;
      cyc         = 0;
      n_xfer      = 0;
      n_acc       = 0;
      fork
         // cycle counter
         forever begin
            @(posedge clock);
            cyc++;
         end
         // out_ready driver
         forever begin
            @(posedge clock);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : force_ready;
         end
         // input driver: holds a beat until accepted
         forever begin
            @(posedge clock);
            #1;
            if (in_valid && acc_last) in_valid = 1'b0;
            if (!in_valid && rd_ptr < stim.size() &&
                (!rand_valid || $urandom_range(0, 2) != 0)) begin
               in_x     = stim[rd_ptr].x;
               in_y     = stim[rd_ptr].y;
               in_op    = stim[rd_ptr].op;
               in_valid = 1'b1;
               rd_ptr++;
            end else if (!in_valid) begin
               in_x  = WIDTH'($urandom);
               in_y  = WIDTH'($urandom);
               in_op = 2'($urandom_range(0, 3));
            end
         end
         // monitor / scoreboard
         begin : mon
            exp_t e;
            forever begin
               @(negedge clock or posedge areset);
               if (areset) begin
                  sb.delete();
                  n_xfer     = 0;
                  acc_last   = 1'b0;
                  prev_stall = 1'b0;
               end else begin
                  if (out_valid && out_ready) begin
                     check("beat_expected", 32'(sb.size() != 0), 32'd1);
                     if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("out_z", 32'(out_z), 32'(e.z));
                        check("out_zero", 32'(out_zero), 32'(e.zero));
                        if (chk_lat) check("latency", 32'(cyc - e.cyc), 32'(STAGES));
                     end
                     n_xfer++;
                  end
                  if (prev_stall) begin
                     check("hold_valid", 32'(out_valid), 32'd1);
                     check("hold_z", 32'(out_z), 32'(prev_z));
                     check("hold_zero", 32'(out_zero), 32'(prev_zero));
                  end
                  prev_stall = out_valid && !out_ready;
                  prev_z     = out_z;
                  prev_zero  = out_zero;
                  acc_last   = in_valid && in_ready;
                  if (acc_last) begin
                     e.z    = ref_fn(in_op, in_x, in_y);
                     e.zero = (e.z == '0);
                     e.cyc  = cyc;
                     sb.push_back(e);
                     n_acc++;
                  end
               end
            end
         end
         // main sequence
         begin : main_seq
            int a0;
            int x0;
            beat_t b;
            #3;
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_z", 32'(out_z), 32'd0);
            check("rst_out_zero", 32'(out_zero), 32'd0);
            check("rst_xfer_count", 32'(xfer_count), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            #9;
            areset = 1'b0;

            // all four ops, back-to-back, fixed latency
            chk_lat = 1'b1;
            x0 = n_xfer;
            for (int op = 0; op < 4; op++) begin
               b.x = 8'hF0; b.y = 8'h3C; b.op = 2'(op);
               stim.push_back(b);
            end
            wait_idle(50, "ops");
            check("ops_count", 32'(n_xfer - x0), 32'd4);

            // zero flag set and clear
            b.x = 8'hAA; b.y = 8'h55; b.op = 2'd0;
            stim.push_back(b);
            b.op = 2'd1;
            stim.push_back(b);
            wait_idle(50, "zero");
            chk_lat = 1'b0;

            // backpressure: only STAGES beats fit
            force_ready = 1'b0;
            @(posedge clock);
            #2;
            a0 = n_acc;
            push_rand(5);
            wait_full(20, "bp");
            for (int i = 0; i < 4; i++) begin
               check("bp_in_ready", 32'(in_ready), 32'd0);
               @(negedge clock);
            end
            check("bp_accepted", 32'(n_acc - a0), 32'(STAGES));
            check("bp_out_valid", 32'(out_valid), 32'd1);
            force_ready = 1'b1;
            @(posedge clock);
            #2;
            x0 = n_xfer;
            repeat (5) @(negedge clock);
            check("bp_drain_rate", 32'(n_xfer - x0), 32'd5);
            wait_idle(50, "bp");

            // asynchronous reset with a full pipe
            force_ready = 1'b0;
            @(posedge clock);
            #2;
            push_rand(STAGES);
            wait_full(20, "rst");
            @(posedge clock);
            #1;
            areset = 1'b1;
            #1;
            check("arst_out_valid", 32'(out_valid), 32'd0);
            check("arst_out_z", 32'(out_z), 32'd0);
            check("arst_out_zero", 32'(out_zero), 32'd0);
            check("arst_xfer_count", 32'(xfer_count), 32'd0);
            check("arst_in_ready", 32'(in_ready), 32'd1);
            #2;
            areset = 1'b0;
            force_ready = 1'b1;
            for (int i = 0; i < STAGES + 3; i++) begin
               @(negedge clock);
               check("no_stale", 32'(out_valid), 32'd0);
            end

            // random valid and ready
            rand_valid = 1'b1;
            rand_ready = 1'b1;
            push_rand(1000);
            wait_idle(20000, "rand");
            rand_valid = 1'b0;
            rand_ready = 1'b0;
            @(negedge clock);
            check("rand_transfers", 32'(n_xfer), 32'd1000);
            check("rand_xfer_count", 32'(xfer_count), 32'(16'(n_xfer)));

            // stream to 65537 transfers since reset
            push_rand(65537 - n_xfer);
            wait_idle(70000, "wrap");
            @(negedge clock);
            check("wrap_transfers", 32'(n_xfer), 32'd65537);
            check("wrap_xfer_count", 32'(xfer_count), 32'd1);

            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
      join
   end

endmodule
